fft4_frame_ctrl: RTL and testbench

Frame sequencer for the 4-point FFT core. It accepts a serial stream of 32-bit complex samples and assembles them into 4-sample frames. It presents each frame to the core's parallel inputs, waits the core's fixed pipeline latency, captures the four 36-bit results, and serialises them onto an output stream. It sits between the sample source and the spectrum consumer and owns the core's input and output buses.

---
 rtl/fft4_frame_ctrl_if.sv | 29 ++
 rtl/fft4_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_fft4_frame_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft4_frame_ctrl_if.sv
// Stream and core-bus bundle for the 4-point FFT frame sequencer.
// master = sequencer side, slave = sample source / core / spectrum consumer side.
interface fft4_frame_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [31:0] fft_vin0;
  logic [31:0] fft_vin1;
  logic [31:0] fft_vin2;
  logic [31:0] fft_vin3;
  logic [35:0] fft_vout0;
  logic [35:0] fft_vout1;
  logic [35:0] fft_vout2;
  logic [35:0] fft_vout3;
  logic        m_valid;
  logic        m_ready;
  logic [35:0] m_data;
  logic        m_last;

  modport master (
    input  s_valid, s_data, fft_vout0, fft_vout1, fft_vout2, fft_vout3, m_ready,
    output s_ready, fft_vin0, fft_vin1, fft_vin2, fft_vin3, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, fft_vout0, fft_vout1, fft_vout2, fft_vout3, m_ready,
    input  s_ready, fft_vin0, fft_vin1, fft_vin2, fft_vin3, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fft4_frame_ctrl.sv
// Frame sequencer for the 4-point FFT core: collect 4 samples, wait LATENCY, drain 4 results.
// Optional completed-frame counter port/register enabled by macro FFT4_CTRL_FRAME_CNT_EN.
module fft4_frame_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  fft4_frame_ctrl_if.master bus,
  output logic              busy
`ifdef FFT4_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int DATA_W = 32;
  localparam int RES_W  = 36;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        in_idx_q, in_idx_d;
  logic [1:0]        out_idx_q, out_idx_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] ibuf_q [4];
  logic [DATA_W-1:0] ibuf_d [4];
  logic [RES_W-1:0]  obuf_q [4];
  logic [RES_W-1:0]  obuf_d [4];
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic s_hs;
  logic m_hs;

  // Every output is decoded from registered state so no input-to-output combinational path exists.
  assign bus.s_ready  = (state_q == ST_COLLECT);
  assign bus.m_valid  = (state_q == ST_DRAIN);
  assign bus.m_last   = (state_q == ST_DRAIN) && (out_idx_q == 2'd3);
  assign bus.m_data   = obuf_q[out_idx_q];
  assign busy         = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

  assign bus.fft_vin0 = ibuf_q[0];
  assign bus.fft_vin1 = ibuf_q[1];
  assign bus.fft_vin2 = ibuf_q[2];
  assign bus.fft_vin3 = ibuf_q[3];

  assign s_hs = bus.s_valid && (state_q == ST_COLLECT);
  assign m_hs = bus.m_ready && (state_q == ST_DRAIN);

  always_comb begin
    state_d     = state_q;
    in_idx_d    = in_idx_q;
    out_idx_d   = out_idx_q;
    wait_cnt_d  = wait_cnt_q;
    ibuf_d      = ibuf_q;
    obuf_d      = obuf_q;
    frame_cnt_d = frame_cnt_q;

    // flush wins over any handshake on the same edge; buffers keep their contents
    if (flush) begin
      state_d   = ST_COLLECT;
      in_idx_d  = 2'd0;
      out_idx_d = 2'd0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (s_hs) begin
            ibuf_d[in_idx_q] = bus.s_data;
            in_idx_d         = in_idx_q + 2'd1;
            if (in_idx_q == 2'd3) begin
              state_d    = ST_WAIT;
              wait_cnt_d = WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            obuf_d[0] = bus.fft_vout0;
            obuf_d[1] = bus.fft_vout1;
            obuf_d[2] = bus.fft_vout2;
            obuf_d[3] = bus.fft_vout3;
            out_idx_d = 2'd0;
            state_d   = ST_DRAIN;
          end else begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end
        end
        ST_DRAIN: begin
          if (m_hs) begin
            out_idx_d = out_idx_q + 2'd1;
            if (out_idx_q == 2'd3) begin
              state_d     = ST_COLLECT;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_COLLECT;
      in_idx_q    <= 2'd0;
      out_idx_q   <= 2'd0;
      wait_cnt_q  <= 4'd0;
      frame_cnt_q <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        ibuf_q[i] <= '0;
        obuf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_idx_q    <= in_idx_d;
      out_idx_q   <= out_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      for (int i = 0; i < 4; i++) begin
        ibuf_q[i] <= ibuf_d[i];
        obuf_q[i] <= obuf_d[i];
      end
    end
  end

`ifdef FFT4_CTRL_FRAME_CNT_EN
  assign frame_cnt = frame_cnt_q;
`else
  // Without the counter feature the register has no observer and is left to optimise away.
  logic unused_frame_cnt;
  assign unused_frame_cnt = ^frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// Directed bench for fft4_frame_ctrl with a LATENCY-cycle behavioural 4-point FFT core.
// Covers reset, timing, back-pressure, input gaps, flush, async reset and the optional frame counter.
module tb_fft4_frame_ctrl;

  localparam int LAT = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic flush;
  logic busy;
  int   cyc  = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fc_exp  = 0;
`ifdef FFT4_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  fft4_frame_ctrl_if bus ();

  fft4_frame_ctrl #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
`ifdef FFT4_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] sx(input logic [15:0] v);
    return {{2{v[15]}}, v};
  endfunction

  // Reference 4-point DFT: X1 = (x0-x2) - j(x1-x3), X3 = (x0-x2) + j(x1-x3)
  function automatic logic [143:0] fft_model(input logic [127:0] fr);
    logic signed [17:0] r [4];
    logic signed [17:0] im [4];
    logic signed [17:0] x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;
    for (int k = 0; k < 4; k++) begin
      r[k]  = sx(fr[32*k +: 16]);
      im[k] = sx(fr[32*k+16 +: 16]);
    end
    x0r = r[0] + r[1] + r[2] + r[3];
    x0i = im[0] + im[1] + im[2] + im[3];
    x2r = r[0] - r[1] + r[2] - r[3];
    x2i = im[0] - im[1] + im[2] - im[3];
    x1r = (r[0] - r[2]) + (im[1] - im[3]);
    x1i = (im[0] - im[2]) - (r[1] - r[3]);
    x3r = (r[0] - r[2]) - (im[1] - im[3]);
    x3i = (im[0] - im[2]) + (r[1] - r[3]);
    return {x3i, x3r, x2i, x2r, x1i, x1r, x0i, x0r};
  endfunction

  // Core model: results become valid LAT edges after the inputs settle.
  logic [127:0] pipe [LAT-1];
  logic [143:0] core_out;
  always @(posedge clk) begin
    pipe[0] <= {bus.fft_vin3, bus.fft_vin2, bus.fft_vin1, bus.fft_vin0};
    for (int k = 1; k < LAT-1; k++) pipe[k] <= pipe[k-1];
  end
  always_comb begin
    core_out      = fft_model(pipe[LAT-2]);
    bus.fft_vout0 = core_out[35:0];
    bus.fft_vout1 = core_out[71:36];
    bus.fft_vout2 = core_out[107:72];
    bus.fft_vout3 = core_out[143:108];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input bit fl, output int e);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    flush       = fl;
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_timeout", 1, 0);
    @(posedge clk);
    #1;
    e           = cyc;
    bus.s_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic pull(input logic [35:0] exp, input bit last, output int e);
    int n = 0;
    bus.m_ready = 1'b1;
    while (!bus.m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("pull_timeout", 1, 0);
    check("beat_data", bus.m_data, exp);
    check("beat_last", bus.m_last, last);
    @(posedge clk);
    #1;
    e = cyc;
  endtask

  task automatic send_frame(input logic [127:0] fr, input bit gaps, output int e_first, output int t3);
    int e;
    for (int i = 0; i < 4; i++) begin
      push(fr[32*i +: 32], 1'b0, e);
      if (i == 0) e_first = e;
      if (gaps && i < 3) begin
        @(negedge clk);
        check("gap_s_ready", bus.s_ready, 1);
        @(posedge clk);
        #1;
      end
    end
    t3 = e;
    check("vin0", bus.fft_vin0, fr[31:0]);
    check("vin1", bus.fft_vin1, fr[63:32]);
    check("vin2", bus.fft_vin2, fr[95:64]);
    check("vin3", bus.fft_vin3, fr[127:96]);
  endtask

  task automatic drain_frame(input logic [127:0] fr, input int stall_beat);
    logic [143:0] ex;
    int e;
    ex = fft_model(fr);
    for (int b = 0; b < 4; b++) begin
      if (b == stall_beat) begin
        bus.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_valid", bus.m_valid, 1);
          check("stall_data", bus.m_data, ex[36*b +: 36]);
          check("stall_last", bus.m_last, (b == 3));
          check("stall_s_ready", bus.s_ready, 0);
        end
      end
      pull(ex[36*b +: 36], (b == 3), e);
    end
    fc_exp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e, t3, ef;
    logic [143:0] ex;
    bit seen;
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_vin", {bus.fft_vin0, bus.fft_vin1, bus.fft_vin2, bus.fft_vin3}, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: samples 1..4, m_ready tied high, hand-computed spectrum
    bus.m_ready = 1'b1;
    send_frame({32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, e0, t3);
    check("f1_span", t3 - e0, 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("f1_wait_m_valid", bus.m_valid, 0);
      check("f1_wait_busy", busy, 1);
      check("f1_wait_s_ready", bus.s_ready, 0);
    end
    pull(36'h00000000A, 1'b0, e);
    check("f1_beat0_edge", e - t3, LAT + 1);
    pull(36'h0000BFFFE, 1'b0, e);
    pull(36'h00003FFFE, 1'b0, e);
    pull(36'hFFFFBFFFE, 1'b1, e);
    check("f1_last_edge", e - e0, 11);
    fc_exp++;

    // Frame 2: back-to-back, extremes, 5-cycle back-pressure on beat 2
    send_frame({32'h8000_7FFF, 32'h0010_FFF0, 32'hFFFE_0007, 32'h0003_0005}, 1'b0, ef, t3);
    check("f2_period", ef - e0, 12);
    drain_frame({32'h8000_7FFF, 32'h0010_FFF0, 32'hFFFE_0007, 32'h0003_0005}, 2);

    // Frame 3: samples on alternate cycles
    send_frame({32'h7FFF_8000, 32'hABCD_0123, 32'h0042_FF00, 32'h1234_5678}, 1'b1, ef, t3);
    drain_frame({32'h7FFF_8000, 32'hABCD_0123, 32'h0042_FF00, 32'h1234_5678}, -1);
`ifdef FFT4_CTRL_FRAME_CNT_EN
    check("frame_cnt_3", frame_cnt, 3);
`endif

    // Flush on the edge accepting sample 2
    push(32'hDEAD_0001, 1'b0, e);
    push(32'hDEAD_0002, 1'b0, e);
    push(32'hDEAD_0003, 1'b1, e);
    check("flush_c_s_ready", bus.s_ready, 1);
    check("flush_c_m_valid", bus.m_valid, 0);
    check("flush_c_busy", busy, 0);
    send_frame({32'h0004_0040, 32'h0003_0030, 32'h0002_0020, 32'h0001_0010}, 1'b0, ef, t3);
    drain_frame({32'h0004_0040, 32'h0003_0030, 32'h0002_0020, 32'h0001_0010}, -1);

    // Flush in DRAIN on beat 1
    send_frame({32'hFFFF_FFFF, 32'h0000_0100, 32'hF000_000F, 32'h0101_0202}, 1'b0, ef, t3);
    ex = fft_model({32'hFFFF_FFFF, 32'h0000_0100, 32'hF000_000F, 32'h0101_0202});
    pull(ex[35:0], 1'b0, e);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_d_m_valid", bus.m_valid, 0);
    check("flush_d_m_last", bus.m_last, 0);
    check("flush_d_s_ready", bus.s_ready, 1);
    check("flush_d_busy", busy, 0);
    send_frame({32'h0000_0009, 32'h0007_0000, 32'h0000_FFFB, 32'hFFFD_0000}, 1'b0, ef, t3);
    drain_frame({32'h0000_0009, 32'h0007_0000, 32'h0000_FFFB, 32'hFFFD_0000}, -1);
`ifdef FFT4_CTRL_FRAME_CNT_EN
    check("frame_cnt_flush", frame_cnt, fc_exp);
`endif

    // Asynchronous reset while in WAIT
    send_frame({32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_0888}, 1'b0, ef, t3);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_s_ready", bus.s_ready, 1);
    check("arst_m_valid", bus.m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_m_data", bus.m_data, 0);
    check("arst_vin", {bus.fft_vin0, bus.fft_vin1, bus.fft_vin2, bus.fft_vin3}, 0);
    fc_exp = 0;
`ifdef FFT4_CTRL_FRAME_CNT_EN
    check("arst_frame_cnt", frame_cnt, 0);
`endif
    @(negedge clk) rstn = 1'b1;
    bus.m_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.m_valid) seen = 1'b1;
    end
    check("arst_no_beat", seen, 0);
    @(posedge clk);
    #1;
    send_frame({32'h0001_0001, 32'hFFFF_0002, 32'h0003_FFFC, 32'h0020_0010}, 1'b0, ef, t3);
    drain_frame({32'h0001_0001, 32'hFFFF_0002, 32'h0003_FFFC, 32'h0020_0010}, 1);

`ifdef FFT4_CTRL_FRAME_CNT_EN
    check("frame_cnt_after_rst", frame_cnt, fc_exp);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    send_frame({32'd8, 32'd7, 32'd6, 32'd5}, 1'b0, ef, t3);
    drain_frame({32'd8, 32'd7, 32'd6, 32'd5}, -1);
    check("frame_cnt_wrap", frame_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
